// File: rtl/codeword_unpacker.sv
// MSB-first bit unpacker: packed words are loaded into an MSB-aligned reservoir.
// Variable-length fields are peeked from the top of the reservoir and then consumed.
module codeword_unpacker #(
   parameter  int IN_W    = 32,
   parameter  int MAX_LEN = 16,
   parameter  int LEN_W   = 5,
   localparam int BUF_W   = IN_W + MAX_LEN,
   localparam int CNT_W   = $clog2(BUF_W + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [IN_W-1:0]    in_data_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [LEN_W-1:0]   fld_len_i,
   input  logic               fld_ready_i,
   output logic               fld_valid_o,
   output logic [MAX_LEN-1:0] fld_data_o,
   input  logic               flush_i,
   output logic [CNT_W-1:0]   level_o
);

   logic [BUF_W-1:0] buf_q, buf_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] lap;
   logic [LEN_W-1:0] len_c, shamt;
   logic             pop, push;

   assign len_c       = (fld_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fld_len_i;
   assign shamt       = LEN_W'(MAX_LEN) - len_c;
   assign fld_valid_o = !rst && (level_q >= CNT_W'(len_c));
   assign fld_data_o  = fld_valid_o ? (buf_q[BUF_W-1 -: MAX_LEN] >> shamt) : '0;
   // Ready depends only on registered level, never on the field handshake.
   assign in_ready_o  = !rst && !flush_i && (level_q <= CNT_W'(BUF_W - IN_W));
   assign pop         = fld_valid_o && fld_ready_i && !flush_i;
   assign push        = in_valid_i && in_ready_o;
   assign level_o     = level_q;

   always_comb begin
      buf_d   = buf_q;
      level_d = level_q;
      lap     = level_q;
      if (pop) begin
         buf_d = buf_q << len_c;
         lap   = level_q - CNT_W'(len_c);
      end
      level_d = lap;
      // New word lands directly behind the bits that survive this cycle's pop.
      if (push) begin
         buf_d   = (buf_d & ~({BUF_W{1'b1}} >> lap)) | ({in_data_i, {MAX_LEN{1'b0}}} >> lap);
         level_d = lap + CNT_W'(IN_W);
      end
      if (flush_i) begin
         buf_d   = '0;
         level_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q   <= '0;
         level_q <= '0;
      end else begin
         buf_q   <= buf_d;
         level_q <= level_d;
      end
   end

endmodule

// File: tb/tb_codeword_unpacker.sv
// Directed scenarios plus a randomized stream checked against a bit-queue model.
module tb_codeword_unpacker;

   logic        clk;
   logic        rst;
   logic [31:0] in_data_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [4:0]  fld_len_i;
   logic        fld_ready_i;
   logic        fld_valid_o;
   logic [15:0] fld_data_o;
   logic        flush_i;
   logic [5:0]  level_o;

   int nchk = 0;
   int nerr = 0;

   codeword_unpacker dut (
      .clk(clk), .rst(rst),
      .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .fld_len_i(fld_len_i), .fld_ready_i(fld_ready_i), .fld_valid_o(fld_valid_o),
      .fld_data_o(fld_data_o), .flush_i(flush_i), .level_o(level_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      assert (fld_len_i <= 5'd16) else $error("illegal fld_len_i %0d", fld_len_i);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [31:0] d);
      in_data_i  = d;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
   endtask

   task automatic do_pop(input logic [4:0] len);
      fld_len_i   = len;
      fld_ready_i = 1'b1;
      step();
      fld_ready_i = 1'b0;
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_data_i = '0; in_valid_i = 1'b0; fld_len_i = 5'd0;
      fld_ready_i = 1'b0; flush_i = 1'b0;
      step(); step();
      #1;
      nchk++; if (level_o !== 6'd0) begin nerr++; $display("FAIL rst_level got %0d exp 0", level_o); end
      nchk++; if (fld_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b exp 0", fld_valid_o); end
      nchk++; if (fld_data_o !== 16'h0) begin nerr++; $display("FAIL rst_data got %h exp 0000", fld_data_o); end
      nchk++; if (in_ready_o !== 1'b0) begin nerr++; $display("FAIL rst_ready got %b exp 0", in_ready_o); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      #1;
      nchk++; if (in_ready_o !== 1'b1) begin nerr++; $display("FAIL t1_ready got %b exp 1", in_ready_o); end
      do_push(32'hDEADBEEF);
      fld_len_i = 5'd4; #1;
      nchk++; if (level_o !== 6'd32) begin nerr++; $display("FAIL t1_lvl32 got %0d exp 32", level_o); end
      nchk++; if (fld_data_o !== 16'h000D) begin nerr++; $display("FAIL t1_len4 got %h exp 000d", fld_data_o); end
      do_pop(5'd4);
      fld_len_i = 5'd8; #1;
      nchk++; if (level_o !== 6'd28) begin nerr++; $display("FAIL t1_lvl28 got %0d exp 28", level_o); end
      nchk++; if (fld_data_o !== 16'h00EA) begin nerr++; $display("FAIL t1_len8 got %h exp 00ea", fld_data_o); end
      do_pop(5'd8);
      fld_len_i = 5'd0; #1;
      nchk++; if (level_o !== 6'd20) begin nerr++; $display("FAIL t1_lvl20 got %0d exp 20", level_o); end
      nchk++; if ({fld_valid_o, fld_data_o} !== {1'b1, 16'h0}) begin nerr++; $display("FAIL t1_len0 got %b/%h exp 1/0000", fld_valid_o, fld_data_o); end
      do_pop(5'd0);
      nchk++; if (level_o !== 6'd20) begin nerr++; $display("FAIL t1_len0_lvl got %0d exp 20", level_o); end
   endtask

   task automatic test_straddle();
      do_flush();
      do_push(32'h0000000F);
      do_pop(5'd16);
      do_pop(5'd12);
      nchk++; if (level_o !== 6'd4) begin nerr++; $display("FAIL t2_lvl4 got %0d exp 4", level_o); end
      do_push(32'hF0000000);
      fld_len_i = 5'd8; #1;
      nchk++; if (fld_data_o !== 16'h00FF) begin nerr++; $display("FAIL t2_len8 got %h exp 00ff", fld_data_o); end
      do_pop(5'd8);
      nchk++; if (level_o !== 6'd28) begin nerr++; $display("FAIL t2_lvl28 got %0d exp 28", level_o); end
   endtask

   task automatic test_backpressure();
      do_flush();
      do_push(32'hA5A5A5A5);
      in_data_i = 32'h3C3C3C3C; in_valid_i = 1'b1; #1;
      nchk++; if (in_ready_o !== 1'b0) begin nerr++; $display("FAIL t3_blocked got %b exp 0", in_ready_o); end
      step();
      nchk++; if (level_o !== 6'd32) begin nerr++; $display("FAIL t3_held_lvl got %0d exp 32", level_o); end
      fld_len_i = 5'd16; fld_ready_i = 1'b1; #1;
      nchk++; if (fld_data_o !== 16'hA5A5) begin nerr++; $display("FAIL t3_pop_data got %h exp a5a5", fld_data_o); end
      step();
      fld_ready_i = 1'b0; #1;
      nchk++; if ({level_o, in_ready_o} !== {6'd16, 1'b1}) begin nerr++; $display("FAIL t3_open got %0d/%b exp 16/1", level_o, in_ready_o); end
      step();
      in_valid_i = 1'b0; #1;
      nchk++; if ({level_o, in_ready_o} !== {6'd48, 1'b0}) begin nerr++; $display("FAIL t3_full got %0d/%b exp 48/0", level_o, in_ready_o); end
      nchk++; if (fld_data_o !== 16'hA5A5) begin nerr++; $display("FAIL t3_data1 got %h exp a5a5", fld_data_o); end
      do_pop(5'd16);
      nchk++; if (fld_data_o !== 16'h3C3C) begin nerr++; $display("FAIL t3_data2 got %h exp 3c3c", fld_data_o); end
   endtask

   task automatic test_back_to_back();
      do_flush();
      do_push(32'h000ABCDE);
      do_pop(5'd12);
      do_pop(5'd4);
      nchk++; if (level_o !== 6'd16) begin nerr++; $display("FAIL t4_lvl16 got %0d exp 16", level_o); end
      // pop 4 and push on the same edge
      fld_len_i = 5'd4; fld_ready_i = 1'b1; in_data_i = 32'h12345678; in_valid_i = 1'b1; #1;
      nchk++; if (fld_data_o !== 16'h000B) begin nerr++; $display("FAIL t4_pop4 got %h exp 000b", fld_data_o); end
      step();
      fld_ready_i = 1'b0; in_valid_i = 1'b0; fld_len_i = 5'd16; #1;
      nchk++; if (level_o !== 6'd44) begin nerr++; $display("FAIL t4_lvl44 got %0d exp 44", level_o); end
      nchk++; if (fld_data_o !== 16'hCDE1) begin nerr++; $display("FAIL t4_f1 got %h exp cde1", fld_data_o); end
      do_pop(5'd16);
      nchk++; if (fld_data_o !== 16'h2345) begin nerr++; $display("FAIL t4_f2 got %h exp 2345", fld_data_o); end
      do_pop(5'd16);
      fld_len_i = 5'd12; #1;
      nchk++; if ({level_o, fld_data_o} !== {6'd12, 16'h0678}) begin nerr++; $display("FAIL t4_f3 got %0d/%h exp 12/0678", level_o, fld_data_o); end
   endtask

   task automatic test_underflow_flush();
      do_flush();
      do_push(32'h00000005);
      do_pop(5'd16);
      do_pop(5'd13);
      fld_len_i = 5'd5; fld_ready_i = 1'b1; #1;
      nchk++; if ({fld_valid_o, fld_data_o} !== {1'b0, 16'h0}) begin nerr++; $display("FAIL t5_under got %b/%h exp 0/0000", fld_valid_o, fld_data_o); end
      step();
      fld_ready_i = 1'b0; fld_len_i = 5'd3; #1;
      nchk++; if ({level_o, fld_data_o} !== {6'd3, 16'h0005}) begin nerr++; $display("FAIL t5_keep got %0d/%h exp 3/0005", level_o, fld_data_o); end
      flush_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hFFFFFFFF; fld_ready_i = 1'b1; #1;
      nchk++; if ({in_ready_o, fld_valid_o} !== 2'b01) begin nerr++; $display("FAIL t5_flush_hs got %b%b exp 01", in_ready_o, fld_valid_o); end
      step();
      flush_i = 1'b0; in_valid_i = 1'b0; fld_ready_i = 1'b0; #1;
      nchk++; if (level_o !== 6'd0) begin nerr++; $display("FAIL t5_flushed got %0d exp 0", level_o); end
   endtask

   task automatic test_reset_mid();
      do_push(32'h11112222);
      do_pop(5'd16);
      do_push(32'h33334444);
      do_pop(5'd8);
      nchk++; if (level_o !== 6'd40) begin nerr++; $display("FAIL t6_lvl40 got %0d exp 40", level_o); end
      in_valid_i = 1'b1; fld_ready_i = 1'b1; fld_len_i = 5'd8; rst = 1'b1;
      step();
      rst = 1'b0; in_valid_i = 1'b0; fld_ready_i = 1'b0; fld_len_i = 5'd1; #1;
      nchk++; if ({level_o, fld_valid_o, fld_data_o} !== {6'd0, 1'b0, 16'h0}) begin nerr++; $display("FAIL t6_rst got %0d/%b/%h exp 0/0/0000", level_o, fld_valid_o, fld_data_o); end
   endtask

   task automatic test_random();
      bit q[$];
      logic [15:0] ed;
      logic [5:0]  el;
      logic        ev, er;
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         rst         = ($urandom_range(0, 999) == 0);
         flush_i     = ($urandom_range(0, 63) == 0);
         in_valid_i  = $urandom_range(0, 1);
         in_data_i   = $urandom;
         fld_ready_i = $urandom_range(0, 1);
         fld_len_i   = 5'($urandom_range(0, 16));
         #1;
         el = 6'(q.size());
         ev = !rst && (q.size() >= int'(fld_len_i));
         er = !rst && !flush_i && (q.size() <= 16);
         ed = '0;
         if (ev) for (int i = 0; i < int'(fld_len_i); i++) ed = {ed[14:0], q[i]};
         nchk++;
         if ({level_o, in_ready_o, fld_valid_o, fld_data_o} !== {el, er, ev, ed}) begin
            nerr++;
            $display("FAIL rand_c%0d got lvl=%0d rdy=%b vld=%b data=%h exp lvl=%0d rdy=%b vld=%b data=%h",
                     c, level_o, in_ready_o, fld_valid_o, fld_data_o, el, er, ev, ed);
         end
         if (rst || flush_i) q.delete();
         else begin
            if (ev && fld_ready_i) for (int i = 0; i < int'(fld_len_i); i++) void'(q.pop_front());
            if (in_valid_i && er) for (int i = 31; i >= 0; i--) q.push_back(in_data_i[i]);
         end
         step();
      end
      rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; fld_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_straddle();
      test_backpressure();
      test_back_to_back();
      test_underflow_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
